pulse_sequencer: RTL and testbench
==================================

PULSE_SEQUENCER -- requirements
Module: pulse_sequencer

Parameters
REQ-001 TIMEOUT_TICKS, default 50: maximum tick gap allowed between bytes of one frame.
REQ-002 CMD_START, default 8'h01: command byte that starts playback.
REQ-003 CMD_ABORT, default 8'h02: command byte that stops playback.

Interface
REQ-004 clk  in  1  single clock; every register SHALL be clocked on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 rx_valid  in  1  one-clk strobe: Rx_Byte holds a new byte.
REQ-007 Rx_Byte  in  8  received UART byte.
REQ-008 tick  in  1  one-clk timebase strobe; all durations are counted in ticks.
REQ-009 abort  in  1  level input; when high, stops playback and discards any partial frame.
REQ-010 drive_high  out  1  high when state is HIGH.
REQ-011 drive_imp  out  1  high when state is IMP.
REQ-012 phase  out  3  state code: IDLE=0, HIGH=1, LOW=2, IMP=3, STOP=4.
REQ-013 busy  out  1  high when state is not IDLE.
REQ-014 rep_left  out  8  remaining repetitions, including the current one.
REQ-015 frame_ok  out  1  one-clk pulse: frame accepted.
REQ-016 frame_err  out  1  one-clk pulse: frame rejected or timed out.
REQ-017 done  out  1  one-clk pulse: playback finished normally.

Function
REQ-018 Frame format: 11 bytes in this order, 16-bit fields little-endian.
- cmd, rep_no
- high_ON lo/hi, low_ON lo/hi
- imp_ON lo/hi, stop_ON lo/hi
REQ-019 Frame byte index: 0..10.
- Advances only on rx_valid.
- Incoming bytes are written to shadow registers.
- After byte 10 the index wraps to 0.
REQ-020 Inter-byte timeout: counts ticks while the index is not 0.
- Cleared on each rx_valid.
- On reaching TIMEOUT_TICKS: index set to 0, shadow registers discarded, frame_err pulses.
REQ-021 Frame response: one clk after byte 10's rx_valid, by state.
- IDLE and cmd==CMD_START: shadow copied to active registers, rep_left loaded with rep_no, frame_ok pulses.
  - If rep_no!=0: enter HIGH in that same clk.
  - If rep_no==0: done pulses in that same clk; state stays IDLE.
- Busy and cmd==CMD_ABORT: frame_ok pulses; state goes to IDLE; done is not pulsed.
- Any other cmd/state combination: frame_err pulses; active registers unchanged.
REQ-022 Phase sequence: HIGH -> LOW -> IMP -> STOP.
- Each phase lasts its *_ON value in ticks.
- A phase counter clears on phase entry and increments on each tick.
- The phase exits on the clk after the tick that makes the count equal its duration.
REQ-023 A phase with duration 0 is held for exactly one clk; its drive output is not asserted.
REQ-024 STOP exit, by rep_left.
- rep_left>1: decrement rep_left, enter HIGH.
- rep_left==1: set rep_left to 0, pulse done, enter IDLE.
REQ-025 abort high:
- Next clk: state IDLE, index 0, rep_left 0.
- No done pulse.
- Has priority over a frame completing in the same clk; that frame is discarded with no frame_ok and no frame_err.
REQ-026 rx_valid and tick in the same clk are both processed.
REQ-027 Phase counter width: 16 bits, so a 16'hFFFF duration lasts 65535 ticks without wrap.
REQ-028 While playback runs, bytes keep loading into the shadow registers; the active parameters stay unchanged until the next accepted CMD_START.

Reset
REQ-029 rst SHALL set every output low/zero:
- drive_high=0, drive_imp=0, phase=0, busy=0, rep_left=0
- frame_ok=0, frame_err=0, done=0
REQ-030 rst SHALL also clear the byte index, timeout counter, phase counter and shadow/active registers to 0.
REQ-031 rst mid-frame or mid-playback SHALL take effect immediately, and no pulse output SHALL fire.

Verification
REQ-032 Frame 01,02,03 00,02 00,01 00,01 00 with tick every clk -> per repetition:
- drive_high for 3 ticks, then LOW 2 ticks, then drive_imp 1 tick, then STOP 1 tick;
- 2 repetitions, rep_left 2->1->0, then a single done pulse.
REQ-033 Frame with rep_no=0 and cmd 01 -> frame_ok and done in the same clk; busy stays 0.
REQ-034 Send 5 bytes, then 50 ticks with no rx_valid -> frame_err pulse; the next 11 bytes are accepted as a fresh frame.
REQ-035 During playback send an 02 frame -> frame_ok, IDLE next clk, no done pulse.
REQ-036 During playback send an 01 frame -> frame_err; playback continues unchanged.
REQ-037 Zero and boundary checks:
- high_ON=0 -> HIGH held 1 clk with drive_high=0.
- abort asserted in the clk byte 10 arrives -> no frame_ok, no frame_err, IDLE.
- rst asserted mid-IMP -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/pulse_sequencer.sv
// pulse_sequencer: collects 11-byte UART command frames and plays a HIGH/LOW/IMP/STOP
// pulse pattern, each phase timed in ticks, repeated rep_no times.
module pulse_sequencer #(
  parameter int unsigned TIMEOUT_TICKS = 50,
  parameter logic [7:0]  CMD_START     = 8'h01,
  parameter logic [7:0]  CMD_ABORT     = 8'h02
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] Rx_Byte,
  input  logic       tick,
  input  logic       abort,
  output logic       drive_high,
  output logic       drive_imp,
  output logic [2:0] phase,
  output logic       busy,
  output logic [7:0] rep_left,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HIGH = 3'd1,
    S_LOW  = 3'd2,
    S_IMP  = 3'd3,
    S_STOP = 3'd4
  } state_t;

  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_TICKS - 1);
  localparam logic [3:0]  LAST_IDX = 4'd10;

  state_t      state, state_nx;
  logic [3:0]  idx;
  logic [15:0] to_cnt;
  logic [15:0] ph_cnt;
  logic [15:0] ph_dur;
  logic [7:0]  sh_cmd, sh_rep;
  logic [15:0] sh_high, sh_low, sh_imp, sh_stop;
  logic [15:0] act_high, act_low, act_imp, act_stop;
  logic        frame_end, timeout, ph_exit, load;
  logic [7:0]  rep_nx;
  logic        ok_nx, err_nx, done_nx;

  // Byte 10 only closes the frame; its value carries no field.
  assign frame_end = rx_valid && (idx == LAST_IDX);
  assign timeout   = !rx_valid && tick && (idx != 4'd0) && (to_cnt == TO_LAST);

  always_comb begin
    case (state)
      S_HIGH:  ph_dur = act_high;
      S_LOW:   ph_dur = act_low;
      S_IMP:   ph_dur = act_imp;
      S_STOP:  ph_dur = act_stop;
      default: ph_dur = 16'd0;
    endcase
  end

  // A zero-length phase exits immediately, so it is held for exactly one clk.
  assign ph_exit = (state != S_IDLE) && (ph_cnt == ph_dur);

  always_comb begin
    state_nx = state;
    rep_nx   = rep_left;
    ok_nx    = 1'b0;
    err_nx   = 1'b0;
    done_nx  = 1'b0;
    load     = 1'b0;
    if (abort) begin
      state_nx = S_IDLE;
      rep_nx   = 8'd0;
    end else begin
      if (ph_exit) begin
        case (state)
          S_HIGH: state_nx = S_LOW;
          S_LOW:  state_nx = S_IMP;
          S_IMP:  state_nx = S_STOP;
          S_STOP: begin
            if (rep_left > 8'd1) begin
              rep_nx   = rep_left - 8'd1;
              state_nx = S_HIGH;
            end else begin
              rep_nx   = 8'd0;
              done_nx  = 1'b1;
              state_nx = S_IDLE;
            end
          end
          default: state_nx = S_IDLE;
        endcase
      end
      if (frame_end) begin
        if ((state == S_IDLE) && (sh_cmd == CMD_START)) begin
          load   = 1'b1;
          ok_nx  = 1'b1;
          rep_nx = sh_rep;
          if (sh_rep != 8'd0) state_nx = S_HIGH;
          else                done_nx  = 1'b1;
        end else if ((state != S_IDLE) && (sh_cmd == CMD_ABORT)) begin
          ok_nx    = 1'b1;
          state_nx = S_IDLE;
          rep_nx   = 8'd0;
          done_nx  = 1'b0;
        end else begin
          err_nx = 1'b1;
        end
      end
      if (timeout) err_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= 4'd0;
      to_cnt    <= 16'd0;
      ph_cnt    <= 16'd0;
      sh_cmd    <= 8'd0;
      sh_rep    <= 8'd0;
      sh_high   <= 16'd0;
      sh_low    <= 16'd0;
      sh_imp    <= 16'd0;
      sh_stop   <= 16'd0;
      act_high  <= 16'd0;
      act_low   <= 16'd0;
      act_imp   <= 16'd0;
      act_stop  <= 16'd0;
      rep_left  <= 8'd0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      done      <= 1'b0;
    end else begin
      rep_left  <= rep_nx;
      frame_ok  <= ok_nx;
      frame_err <= err_nx;
      done      <= done_nx;

      if (abort)         idx <= 4'd0;
      else if (rx_valid) idx <= (idx == LAST_IDX) ? 4'd0 : idx + 4'd1;
      else if (timeout)  idx <= 4'd0;

      if (abort || rx_valid || timeout || (idx == 4'd0)) to_cnt <= 16'd0;
      else if (tick)                                       to_cnt <= to_cnt + 16'd1;

      if (state_nx != state)                             ph_cnt <= 16'd0;
      else if (tick && !ph_exit && (state != S_IDLE))    ph_cnt <= ph_cnt + 16'd1;

      // A discarded partial frame leaves no stale bytes behind.
      if (abort || timeout) begin
        sh_cmd  <= 8'd0;
        sh_rep  <= 8'd0;
        sh_high <= 16'd0;
        sh_low  <= 16'd0;
        sh_imp  <= 16'd0;
        sh_stop <= 16'd0;
      end else if (rx_valid) begin
        case (idx)
          4'd0:    sh_cmd        <= Rx_Byte;
          4'd1:    sh_rep        <= Rx_Byte;
          4'd2:    sh_high[7:0]  <= Rx_Byte;
          4'd3:    sh_high[15:8] <= Rx_Byte;
          4'd4:    sh_low[7:0]   <= Rx_Byte;
          4'd5:    sh_low[15:8]  <= Rx_Byte;
          4'd6:    sh_imp[7:0]   <= Rx_Byte;
          4'd7:    sh_imp[15:8]  <= Rx_Byte;
          4'd8:    sh_stop[7:0]  <= Rx_Byte;
          4'd9:    sh_stop[15:8] <= Rx_Byte;
          default: ;
        endcase
      end

      if (load) begin
        act_high <= sh_high;
        act_low  <= sh_low;
        act_imp  <= sh_imp;
        act_stop <= sh_stop;
      end
    end
  end

  assign phase      = 3'(state);
  assign busy       = (state != S_IDLE);
  assign drive_high = (state == S_HIGH) && (act_high != 16'd0);
  assign drive_imp  = (state == S_IMP) && (act_imp != 16'd0);

endmodule

// File: tb/tb_pulse_sequencer.sv
// Bench for pulse_sequencer: directed scenarios plus randomized frames, every clk
// compared against a frame/phase-level reference model.
module tb_pulse_sequencer;

  localparam int TO = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid, tick, abort;
  logic [7:0] Rx_Byte;
  logic       drive_high, drive_imp, busy, frame_ok, frame_err, done;
  logic [2:0] phase;
  logic [7:0] rep_left;

  pulse_sequencer #(.TIMEOUT_TICKS(TO), .CMD_START(8'h01), .CMD_ABORT(8'h02)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .Rx_Byte(Rx_Byte), .tick(tick),
    .abort(abort), .drive_high(drive_high), .drive_imp(drive_imp), .phase(phase),
    .busy(busy), .rep_left(rep_left), .frame_ok(frame_ok), .frame_err(frame_err),
    .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int seen_ok, seen_err, seen_done, seen_okdone, max_rep, high_clks;

  // Reference model: received bytes queue, playback as phase number 1..4 plus tick count.
  logic [7:0]  q[$];
  int          m_to, m_ph, m_cnt;
  logic [7:0]  m_rep;
  logic [15:0] m_dur[1:4];
  logic        m_ok, m_err, m_done;
  logic [7:0]  fr[11];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_to = 0; m_ph = 0; m_cnt = 0; m_rep = 8'd0;
    for (int i = 1; i <= 4; i++) m_dur[i] = 16'd0;
    m_ok = 1'b0; m_err = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_step(input logic rv, input logic [7:0] b, input logic tk, input logic ab);
    int nph;
    m_ok = 1'b0; m_err = 1'b0; m_done = 1'b0;
    if (ab) begin
      q.delete(); m_to = 0; m_ph = 0; m_cnt = 0; m_rep = 8'd0;
      return;
    end
    nph = m_ph;
    if (m_ph != 0) begin
      if (m_cnt == int'(m_dur[m_ph])) begin
        if (m_ph < 4) nph = m_ph + 1;
        else if (m_rep > 8'd1) begin m_rep = m_rep - 8'd1; nph = 1; end
        else begin m_rep = 8'd0; m_done = 1'b1; nph = 0; end
      end else if (tk) m_cnt++;
    end
    if (rv) begin
      q.push_back(b);
      m_to = 0;
      if (q.size() == 11) begin
        if (m_ph == 0 && q[0] == 8'h01) begin
          m_dur[1] = {q[3], q[2]};
          m_dur[2] = {q[5], q[4]};
          m_dur[3] = {q[7], q[6]};
          m_dur[4] = {q[9], q[8]};
          m_rep = q[1];
          m_ok  = 1'b1;
          if (q[1] != 8'd0) nph = 1;
          else              m_done = 1'b1;
        end else if (m_ph != 0 && q[0] == 8'h02) begin
          m_ok = 1'b1; nph = 0; m_rep = 8'd0; m_done = 1'b0;
        end else begin
          m_err = 1'b1;
        end
        q.delete();
      end
    end else if (q.size() != 0 && tk) begin
      m_to++;
      if (m_to == TO) begin m_err = 1'b1; q.delete(); m_to = 0; end
    end
    if (nph != m_ph) m_cnt = 0;
    m_ph = nph;
  endtask

  function automatic logic [16:0] dut_vec();
    return {drive_high, drive_imp, phase, busy, rep_left, frame_ok, frame_err, done};
  endfunction

  function automatic logic [16:0] exp_vec();
    logic dh, di;
    dh = (m_ph == 1) && (m_dur[1] != 16'd0);
    di = (m_ph == 3) && (m_dur[3] != 16'd0);
    return {dh, di, 3'(m_ph), (m_ph != 0), m_rep, m_ok, m_err, m_done};
  endfunction

  task automatic clear_seen();
    seen_ok = 0; seen_err = 0; seen_done = 0; seen_okdone = 0; max_rep = 0; high_clks = 0;
  endtask

  task automatic cycle(input logic rv, input logic [7:0] b, input logic tk, input logic ab);
    rx_valid = rv; Rx_Byte = b; tick = tk; abort = ab;
    @(posedge clk);
    model_step(rv, b, tk, ab);
    #1;
    check("outs", 32'(dut_vec()), 32'(exp_vec()));
    if (frame_ok) seen_ok++;
    if (frame_err) seen_err++;
    if (done) seen_done++;
    if (frame_ok && done) seen_okdone++;
    if (int'(rep_left) > max_rep) max_rep = int'(rep_left);
    if (drive_high) high_clks++;
    rx_valid = 1'b0; tick = 1'b0; abort = 1'b0;
  endtask

  task automatic run(input int n, input int tick_pct, input int abort_pct);
    for (int i = 0; i < n; i++)
      cycle(1'b0, 8'($urandom), 1'($urandom_range(99) < tick_pct), 1'($urandom_range(99) < abort_pct));
  endtask

  task automatic mk_frame(input logic [7:0] cmd, input logic [7:0] rep,
                          input logic [15:0] h, input logic [15:0] l,
                          input logic [15:0] i, input logic [15:0] s);
    fr[0] = cmd;  fr[1] = rep;
    fr[2] = h[7:0]; fr[3] = h[15:8];
    fr[4] = l[7:0]; fr[5] = l[15:8];
    fr[6] = i[7:0]; fr[7] = i[15:8];
    fr[8] = s[7:0]; fr[9] = s[15:8];
    fr[10] = 8'h00;
  endtask

  task automatic send_frame(input int nbytes, input int tick_pct, input int max_gap, input int abort_pct);
    for (int k = 0; k < nbytes; k++) begin
      cycle(1'b1, fr[k], 1'($urandom_range(99) < tick_pct), 1'($urandom_range(99) < abort_pct));
      if (max_gap > 0) run($urandom_range(max_gap), tick_pct, abort_pct);
    end
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; tick = 1'b0; abort = 1'b0; Rx_Byte = 8'h00;
    model_reset();
    clear_seen();
    #12;
    check("reset_outs", 32'(dut_vec()), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Two repetitions of 3/2/1/1 with a tick every clk.
    clear_seen();
    mk_frame(8'h01, 8'd2, 16'd3, 16'd2, 16'd1, 16'd1);
    send_frame(11, 100, 0, 0);
    run(30, 100, 0);
    check("play2_done_cnt", seen_done, 1);
    check("play2_ok_cnt", seen_ok, 1);
    check("play2_max_rep", max_rep, 2);
    check("play2_idle_after", busy, 1'b0);

    // rep_no = 0: frame_ok and done together, never busy.
    clear_seen();
    mk_frame(8'h01, 8'd0, 16'd4, 16'd4, 16'd4, 16'd4);
    send_frame(11, 50, 0, 0);
    run(3, 50, 0);
    check("rep0_okdone", seen_okdone, 1);
    check("rep0_busy", busy, 1'b0);

    // Partial frame times out, then a fresh frame is accepted.
    clear_seen();
    send_frame(5, 0, 0, 0);
    run(TO, 100, 0);
    check("timeout_err", seen_err, 1);
    mk_frame(8'h01, 8'd0, 16'd1, 16'd1, 16'd1, 16'd1);
    send_frame(11, 0, 0, 0);
    check("after_timeout_ok", seen_ok, 1);

    // Abort frame during playback.
    mk_frame(8'h01, 8'd3, 16'd5, 16'd5, 16'd5, 16'd5);
    send_frame(11, 100, 0, 0);
    run(5, 100, 0);
    clear_seen();
    mk_frame(8'h02, 8'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    send_frame(11, 100, 0, 0);
    run(2, 100, 0);
    check("abortfrm_ok", seen_ok, 1);
    check("abortfrm_done", seen_done, 0);
    check("abortfrm_phase", phase, 3'd0);

    // Start frame during playback is rejected; playback keeps old durations.
    mk_frame(8'h01, 8'd3, 16'd5, 16'd5, 16'd5, 16'd5);
    send_frame(11, 100, 0, 0);
    run(3, 100, 0);
    clear_seen();
    mk_frame(8'h01, 8'd1, 16'd9, 16'd0, 16'd0, 16'd0);
    send_frame(11, 100, 0, 0);
    check("busystart_err", seen_err, 1);
    check("busystart_ok", seen_ok, 0);
    check("busystart_busy", busy, 1'b1);
    run(100, 100, 0);
    check("busystart_done", seen_done, 1);

    // Zero-length HIGH phase.
    clear_seen();
    mk_frame(8'h01, 8'd1, 16'd0, 16'd2, 16'd2, 16'd1);
    send_frame(11, 100, 0, 0);
    run(15, 100, 0);
    check("high0_drive", high_clks, 0);
    check("high0_done", seen_done, 1);

    // abort in the clk of byte 10.
    clear_seen();
    mk_frame(8'h01, 8'd1, 16'd2, 16'd2, 16'd2, 16'd2);
    send_frame(10, 50, 0, 0);
    cycle(1'b1, fr[10], 1'b1, 1'b1);
    run(3, 50, 0);
    check("abort10_ok", seen_ok, 0);
    check("abort10_err", seen_err, 0);
    check("abort10_phase", phase, 3'd0);

    // Asynchronous reset in the middle of IMP.
    mk_frame(8'h01, 8'd1, 16'd2, 16'd2, 16'd20, 16'd2);
    send_frame(11, 100, 0, 0);
    for (int i = 0; i < 100; i++) begin
      if (phase == 3'd3) break;
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("imp_reached", phase, 3'd3);
    #2 rst = 1'b1;
    #1 check("rst_async", 32'(dut_vec()), 32'd0);
    @(posedge clk); #1;
    check("rst_held", 32'(dut_vec()), 32'd0);
    rst = 1'b0;
    model_reset();

    // Randomized frames, gaps, aborts and timeouts.
    for (int n = 0; n < 150; n++) begin
      logic [7:0] cmd;
      int pick;
      pick = $urandom_range(9);
      cmd = (pick < 5) ? 8'h01 : (pick < 8) ? 8'h02 : 8'($urandom);
      mk_frame(cmd, 8'($urandom_range(3)), 16'($urandom_range(6)), 16'($urandom_range(6)),
               16'($urandom_range(6)), 16'($urandom_range(6)));
      fr[10] = 8'($urandom);
      if ($urandom_range(9) == 0) begin
        send_frame($urandom_range(1, 10), 50, 2, 0);
        run(TO + 10, 100, 0);
      end else begin
        send_frame(11, 50, 2, 2);
      end
      run($urandom_range(40), 50, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
